game_timer: RTL and testbench



---
 rtl/timer_pkg.sv | 25 ++
 rtl/bcd_digit_counter.sv | 40 ++++
 rtl/game_timer.sv | 137 +++++++++++++
 tb/tb_game_timer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types and constants for the game elapsed-time counter.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } timer_state_t;

    localparam int BCD_W = 4;

    localparam logic [BCD_W-1:0] SEC_TENS_MAX = 4'd5;
    localparam logic [BCD_W-1:0] DIGIT_MAX    = 4'd9;

    // Convert 0..99 into two packed BCD digits {tens, ones}.
    function automatic logic [2*BCD_W-1:0] to_bcd2(input int v);
        logic [BCD_W-1:0] tens;
        logic [BCD_W-1:0] ones;
        tens = BCD_W'(v / 10);
        ones = BCD_W'(v % 10);
        return {tens, ones};
    endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// Single BCD digit that wraps at MAX and signals a carry on wrap.
module bcd_digit_counter
    import timer_pkg::*;
#(
    parameter logic [BCD_W-1:0] MAX = DIGIT_MAX
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [BCD_W-1:0] q,
    output logic             carry
);

    logic [BCD_W-1:0] q_q;
    logic [BCD_W-1:0] q_d;

    // Clear wins over increment; wrap to zero after MAX.
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (en) begin
            q_d = (q_q == MAX) ? '0 : q_q + 1'b1;
        end
    end

    // Digit register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q     = q_q;
    assign carry = en & (q_q == MAX);

endmodule

// File: rtl/game_timer.sv
// MM:SS elapsed-time counter with start/pause/clear control and a minute limit.
module game_timer
    import timer_pkg::*;
#(
    parameter int LIMIT_MIN = 99
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_1Hz,
    input  logic             start,
    input  logic             pause,
    input  logic             clear,
    output logic [BCD_W-1:0] sec_ones,
    output logic [BCD_W-1:0] sec_tens,
    output logic [BCD_W-1:0] min_ones,
    output logic [BCD_W-1:0] min_tens,
    output logic             running,
    output logic             sec_pulse,
    output logic             time_up
);

    // Minutes value from which the next minute carry reaches the limit.
    localparam logic [2*BCD_W-1:0] LAST_MIN = to_bcd2(LIMIT_MIN - 1);

    timer_state_t state_q, state_d;

    logic clk_1Hz_d;
    logic tick;
    logic inc;
    logic load;
    logic expire;
    logic c_so, c_st, c_mo, c_mt;
    logic running_q, sec_pulse_q, time_up_q;

    assign tick = clk_1Hz & ~clk_1Hz_d;

    // A tick counts only while RUNNING and not overridden by clear.
    assign inc  = (state_q == RUNNING) & tick & ~clear;

    // Digits are zeroed on clear and on a start that leaves IDLE.
    assign load = clear | ((state_q == IDLE) & start);

    // Seconds rolling over at the last allowed minute lands exactly on
    // LIMIT_MIN:00. The minute-tens carry (99:59 -> 00:00) is unreachable
    // for a legal limit but is folded in so the display can never wrap.
    assign expire = (c_st & ({min_tens, min_ones} == LAST_MIN)) | c_mt;

    // Rising-edge detector history for the 1 Hz wave.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_1Hz_d <= 1'b0;
        end else begin
            clk_1Hz_d <= clk_1Hz;
        end
    end

    bcd_digit_counter #(.MAX(DIGIT_MAX)) u_sec_ones (
        .clk   (clk),
        .reset (reset),
        .clr   (load),
        .en    (inc),
        .q     (sec_ones),
        .carry (c_so)
    );

    bcd_digit_counter #(.MAX(SEC_TENS_MAX)) u_sec_tens (
        .clk   (clk),
        .reset (reset),
        .clr   (load),
        .en    (c_so),
        .q     (sec_tens),
        .carry (c_st)
    );

    bcd_digit_counter #(.MAX(DIGIT_MAX)) u_min_ones (
        .clk   (clk),
        .reset (reset),
        .clr   (load),
        .en    (c_st),
        .q     (min_ones),
        .carry (c_mo)
    );

    bcd_digit_counter #(.MAX(DIGIT_MAX)) u_min_tens (
        .clk   (clk),
        .reset (reset),
        .clr   (load),
        .en    (c_mo),
        .q     (min_tens),
        .carry (c_mt)
    );

    // Next-state logic: clear > start > pause; expiry beats a coincident pause.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) state_d = RUNNING;
                end
                RUNNING: begin
                    if (inc && expire) state_d = EXPIRED;
                    else if (pause)    state_d = PAUSED;
                end
                PAUSED: begin
                    if (pause) state_d = RUNNING;
                end
                EXPIRED: begin
                    state_d = EXPIRED;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State register and registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            running_q   <= 1'b0;
            time_up_q   <= 1'b0;
            sec_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            running_q   <= (state_d == RUNNING);
            time_up_q   <= (state_d == EXPIRED);
            sec_pulse_q <= inc;
        end
    end

    assign running   = running_q;
    assign time_up   = time_up_q;
    assign sec_pulse = sec_pulse_q;

endmodule

// File: tb/tb_game_timer.sv
// Directed bench for game_timer: default limit instance plus a 2-minute instance.
module tb_game_timer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic clk_1Hz = 1'b0;
    logic start = 1'b0;
    logic pause = 1'b0;
    logic clear = 1'b0;

    logic [3:0] so, st, mo, mt;
    logic       running, sec_pulse, time_up;
    logic [3:0] so2, st2, mo2, mt2;
    logic       running2, sec_pulse2, time_up2;

    int errors = 0;
    int checks = 0;
    int pcnt   = 0;
    int pcnt2  = 0;

    always #5 clk = ~clk;

    game_timer dut (
        .clk(clk), .reset(reset), .clk_1Hz(clk_1Hz),
        .start(start), .pause(pause), .clear(clear),
        .sec_ones(so), .sec_tens(st), .min_ones(mo), .min_tens(mt),
        .running(running), .sec_pulse(sec_pulse), .time_up(time_up)
    );

    game_timer #(.LIMIT_MIN(2)) dut2 (
        .clk(clk), .reset(reset), .clk_1Hz(clk_1Hz),
        .start(start), .pause(pause), .clear(clear),
        .sec_ones(so2), .sec_tens(st2), .min_ones(mo2), .min_tens(mt2),
        .running(running2), .sec_pulse(sec_pulse2), .time_up(time_up2)
    );

    wire [15:0] disp  = {mt, mo, st, so};
    wire [15:0] disp2 = {mt2, mo2, st2, so2};

    always @(negedge clk) begin
        if (sec_pulse)  pcnt  <= pcnt + 1;
        if (sec_pulse2) pcnt2 <= pcnt2 + 1;
    end

    // One command pulse, sampled on the next rising clk edge.
    task automatic cmd(input logic s, input logic p, input logic c);
        @(posedge clk); #1;
        start = s; pause = p; clear = c;
        @(posedge clk); #1;
        start = 0; pause = 0; clear = 0;
    endtask

    // One 1 Hz period (5 high, 5 low); commands coincide with the tick edge.
    task automatic sec(input logic s, input logic p, input logic c);
        @(posedge clk); #1;
        clk_1Hz = 1; start = s; pause = p; clear = c;
        @(posedge clk); #1;
        start = 0; pause = 0; clear = 0;
        repeat (4) @(posedge clk);
        #1 clk_1Hz = 0;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic secs(input int n);
        for (int i = 0; i < n; i++) sec(0, 0, 0);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({disp, running, sec_pulse, time_up} !== 19'h0) begin
            errors++;
            $display("FAIL reset_outputs: got disp=%h run=%b sp=%b tu=%b, want 0000 0 0 0",
                     disp, running, sec_pulse, time_up);
        end
        @(negedge clk) reset = 0;
        secs(2);
        checks++;
        if (disp !== 16'h0000 || running !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_count: got disp=%h run=%b, want 0000 0", disp, running);
        end
    endtask

    task automatic test_basic();
        int p0;
        cmd(1, 0, 0);
        checks++;
        if (running !== 1'b1 || disp !== 16'h0000) begin
            errors++;
            $display("FAIL start: got run=%b disp=%h, want 1 0000", running, disp);
        end
        p0 = pcnt;
        secs(25);
        checks++;
        if (disp !== 16'h0025) begin
            errors++;
            $display("FAIL basic_disp: got %h, want 0025", disp);
        end
        checks++;
        if (pcnt - p0 !== 25) begin
            errors++;
            $display("FAIL basic_pulses: got %0d, want 25", pcnt - p0);
        end
        checks++;
        if (running !== 1'b1) begin
            errors++;
            $display("FAIL basic_running: got %b, want 1", running);
        end
    endtask

    task automatic test_pause();
        cmd(0, 0, 1);
        cmd(1, 0, 0);
        secs(10);
        cmd(0, 1, 0);
        checks++;
        if (running !== 1'b0) begin
            errors++;
            $display("FAIL pause_running: got %b, want 0", running);
        end
        secs(5);
        checks++;
        if (disp !== 16'h0010 || running !== 1'b0) begin
            errors++;
            $display("FAIL paused_hold: got disp=%h run=%b, want 0010 0", disp, running);
        end
        cmd(0, 1, 0);
        secs(3);
        checks++;
        if (disp !== 16'h0013 || running !== 1'b1) begin
            errors++;
            $display("FAIL resume: got disp=%h run=%b, want 0013 1", disp, running);
        end
    endtask

    task automatic test_rollover();
        cmd(0, 0, 1);
        cmd(1, 0, 0);
        secs(59);
        checks++;
        if (disp !== 16'h0059) begin
            errors++;
            $display("FAIL roll_pre: got %h, want 0059", disp);
        end
        secs(1);
        checks++;
        if (disp !== 16'h0100) begin
            errors++;
            $display("FAIL roll_min: got %h, want 0100", disp);
        end
        secs(539);
        checks++;
        if (disp !== 16'h0959) begin
            errors++;
            $display("FAIL roll_pre10: got %h, want 0959", disp);
        end
        secs(1);
        checks++;
        if (disp !== 16'h1000 || time_up !== 1'b0) begin
            errors++;
            $display("FAIL roll_10min: got disp=%h tu=%b, want 1000 0", disp, time_up);
        end
        checks++;
        if (disp2 !== 16'h0200 || time_up2 !== 1'b1) begin
            errors++;
            $display("FAIL lim2_held: got disp=%h tu=%b, want 0200 1", disp2, time_up2);
        end
    endtask

    task automatic test_expiry();
        int p0;
        cmd(0, 0, 1);
        cmd(1, 0, 0);
        secs(119);
        checks++;
        if (disp2 !== 16'h0159 || time_up2 !== 1'b0 || running2 !== 1'b1) begin
            errors++;
            $display("FAIL exp_pre: got disp=%h tu=%b run=%b, want 0159 0 1",
                     disp2, time_up2, running2);
        end
        p0 = pcnt2;
        secs(1);
        checks++;
        if (disp2 !== 16'h0200 || time_up2 !== 1'b1 || running2 !== 1'b0) begin
            errors++;
            $display("FAIL exp_hit: got disp=%h tu=%b run=%b, want 0200 1 0",
                     disp2, time_up2, running2);
        end
        checks++;
        if (pcnt2 - p0 !== 1) begin
            errors++;
            $display("FAIL exp_pulse: got %0d, want 1", pcnt2 - p0);
        end
        p0 = pcnt2;
        secs(10);
        cmd(1, 0, 0);
        cmd(0, 1, 0);
        checks++;
        if (disp2 !== 16'h0200 || time_up2 !== 1'b1 || pcnt2 - p0 !== 0) begin
            errors++;
            $display("FAIL exp_hold: got disp=%h tu=%b pulses=%0d, want 0200 1 0",
                     disp2, time_up2, pcnt2 - p0);
        end
        cmd(0, 0, 1);
        checks++;
        if (disp2 !== 16'h0000 || time_up2 !== 1'b0) begin
            errors++;
            $display("FAIL exp_clear: got disp=%h tu=%b, want 0000 0", disp2, time_up2);
        end
    endtask

    task automatic test_simultaneous();
        cmd(0, 0, 1);
        cmd(1, 0, 0);
        secs(7);
        sec(0, 1, 0);
        checks++;
        if (disp !== 16'h0008 || running !== 1'b0) begin
            errors++;
            $display("FAIL tick_pause: got disp=%h run=%b, want 0008 0", disp, running);
        end
        secs(2);
        checks++;
        if (disp !== 16'h0008) begin
            errors++;
            $display("FAIL tick_pause_hold: got %h, want 0008", disp);
        end
        cmd(0, 1, 0);
        sec(0, 0, 1);
        secs(1);
        checks++;
        if (disp !== 16'h0000 || running !== 1'b0) begin
            errors++;
            $display("FAIL tick_clear: got disp=%h run=%b, want 0000 0", disp, running);
        end
        sec(1, 0, 0);
        checks++;
        if (disp !== 16'h0000 || running !== 1'b1) begin
            errors++;
            $display("FAIL tick_start: got disp=%h run=%b, want 0000 1", disp, running);
        end
        secs(1);
        checks++;
        if (disp !== 16'h0001) begin
            errors++;
            $display("FAIL after_start: got %h, want 0001", disp);
        end
        cmd(0, 0, 1);
        cmd(1, 1, 0);
        checks++;
        if (running !== 1'b1) begin
            errors++;
            $display("FAIL start_pause_idle: got run=%b, want 1", running);
        end
    endtask

    task automatic test_async_reset();
        cmd(0, 0, 1);
        cmd(1, 0, 0);
        secs(221);
        checks++;
        if (disp !== 16'h0341) begin
            errors++;
            $display("FAIL pre_reset: got %h, want 0341", disp);
        end
        @(negedge clk);
        #1 reset = 1;
        #1;
        checks++;
        if ({disp, running, sec_pulse, time_up} !== 19'h0) begin
            errors++;
            $display("FAIL async_reset: got disp=%h run=%b sp=%b tu=%b, want 0000 0 0 0",
                     disp, running, sec_pulse, time_up);
        end
        @(negedge clk) reset = 0;
        secs(3);
        checks++;
        if (disp !== 16'h0000 || running !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: got disp=%h run=%b, want 0000 0", disp, running);
        end
        cmd(1, 0, 0);
        secs(1);
        checks++;
        if (disp !== 16'h0001) begin
            errors++;
            $display("FAIL post_reset_start: got %h, want 0001", disp);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_pause();
        test_rollover();
        test_expiry();
        test_simultaneous();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
